inst_mem_pipe: RTL

//  Parametrised instruction memory with synchronous read and a valid/ready fetch interface.

---
 rtl/mips_pkg.sv | 14 +
 rtl/imem_rsp_fifo.sv | 56 +++++
 rtl/inst_mem_pipe.sv | 80 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS fetch path: instruction-memory response bundle
// and the canonical NOP word returned on faulting fetches.
package mips_pkg;

    localparam logic [31:0] NOP_INST  = 32'h0000_0000;
    localparam int          RSP_DEPTH = 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        fault;
    } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry response buffer between the instruction memory and fetch;
// lets the core stall fetch without losing or overwriting responses.
module imem_rsp_fifo
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  imem_rsp_t  push_data,
    input  logic       pop,
    output imem_rsp_t  pop_data,
    output logic [1:0] count
);

    imem_rsp_t  r_ent [RSP_DEPTH];
    logic       r_wr;
    logic       r_rd;
    logic [1:0] r_count;

    logic w_push;
    logic w_pop;

    // Guards keep a full buffer from being overwritten and an empty one from underflowing
    assign w_push = push && (r_count != 2'd2);
    assign w_pop  = pop  && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_ent[r_wr] <= push_data;
        end
    end

    assign pop_data = (r_count != 2'd0) ? r_ent[r_rd] : '0;
    assign count    = r_count;

endmodule

// File: rtl/inst_mem_pipe.sv
// Instruction memory with run-time program port and a buffered valid/ready
// fetch interface; misaligned or out-of-range fetches return FAULT_INST.
module inst_mem_pipe
    import mips_pkg::*;
#(
    parameter int                DEPTH      = 32,
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [DATA_W-1:0] FAULT_INST = DATA_W'(NOP_INST)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_inst,
    output logic [ADDR_W-1:0]        rsp_addr,
    output logic                     rsp_fault,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [DATA_W-1:0]        prog_data
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [AW-1:0]     w_idx;
    logic [ADDR_W-1:0] w_hi;
    logic              w_fault;
    logic [DATA_W-1:0] w_inst;
    logic [1:0]        w_count;
    logic              w_push;
    logic              w_pop;
    imem_rsp_t         w_push_data;
    imem_rsp_t         w_pop_data;

    assign w_idx   = req_addr[AW+1:2];
    assign w_hi    = req_addr >> (AW + 2);
    assign w_fault = (req_addr[1:0] != 2'b00) || (w_hi != '0);

    // Read sampled at the same edge as a program write, so a colliding fetch sees the old word
    assign w_inst = w_fault ? FAULT_INST : r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (prog_we && !rst) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // Ready depends only on registered occupancy, never on rsp_ready
    assign req_ready = (w_count < 2'd2);
    assign rsp_valid = (w_count != 2'd0);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = rsp_valid && rsp_ready;

    always_comb begin
        w_push_data       = '0;
        w_push_data.inst  = 32'(w_inst);
        w_push_data.addr  = 32'(req_addr);
        w_push_data.fault = w_fault;
    end

    imem_rsp_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .count     (w_count)
    );

    assign rsp_inst  = DATA_W'(w_pop_data.inst);
    assign rsp_addr  = ADDR_W'(w_pop_data.addr);
    assign rsp_fault = w_pop_data.fault;

endmodule
